// File: rtl/mips_main_fsm.sv
// Multicycle MIPS main controller: Moore FSM that sequences fetch/decode/execute
// and decodes the current state into datapath enables, mux selects and ALU op.
module mips_main_fsm #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct_in,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] funct,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zext_imm,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q;
    state_t state_next;
    logic   illegal_c;
    logic   ready;
    logic   pcwrite_c;
    logic   branch_c;
    logic   irwrite_c;
    logic   memwrite_c;
    logic   regwrite_c;

    assign ready = MEM_WAIT ? mem_ready : 1'b1;

    // State register and registered illegal-opcode pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_next;
            illegal_op <= illegal_c;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next = S_FETCH;
        illegal_c  = 1'b0;
        aluop      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zext_imm   = 1'b0;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                pcwrite_c  = ready;
                irwrite_c  = ready;
                state_next = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYP:      state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_ORI:       state_next = S_ORIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                state_next = ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branch_c = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_IMMWB;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                zext_imm   = 1'b1;
                aluop      = 2'b11;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables are suppressed for the whole time reset is asserted.
    assign pcen     = (pcwrite_c | (branch_c & zero)) & reset_n;
    assign irwrite  = irwrite_c & reset_n;
    assign memwrite = memwrite_c & reset_n;
    assign regwrite = regwrite_c & reset_n;
    assign funct    = funct_in;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_main_fsm.sv
// Directed bench for mips_main_fsm: walks each instruction class through its
// state sequence and checks decoded outputs against hand-computed values.
module tb_mips_main_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct_in;
    logic       zero;
    logic       mem_ready;
    logic [5:0] funct;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext_imm;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] state;
    logic       illegal_op;

    int n_total = 0;
    int n_pass  = 0;

    mips_main_fsm #(.MEM_WAIT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct_in(funct_in),
        .zero(zero), .mem_ready(mem_ready), .funct(funct), .aluop(aluop),
        .alusrca(alusrca), .alusrcb(alusrcb), .zext_imm(zext_imm), .pcsrc(pcsrc),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'b100011;
        funct_in  = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_illegal", 8'(illegal_op), 8'd0);
        chk("rst_irwrite", 8'(irwrite), 8'd0);
        chk("rst_pcen", 8'(pcen), 8'd0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("fetch_irwrite", 8'(irwrite), 8'd1);
        chk("fetch_pcen", 8'(pcen), 8'd1);
        chk("fetch_alusrcb", 8'(alusrcb), 8'd1);

        // lw: 0,1,2,3,4
        step(); chk("lw_s1", 8'(state), 8'd1); chk("lw_decode_srcb", 8'(alusrcb), 8'd3);
        step(); chk("lw_s2", 8'(state), 8'd2); chk("lw_memadr_srcb", 8'(alusrcb), 8'd2);
        chk("lw_memadr_srca", 8'(alusrca), 8'd1);
        step(); chk("lw_s3", 8'(state), 8'd3); chk("lw_memrd_iord", 8'(iord), 8'd1);
        chk("lw_memrd_regwrite", 8'(regwrite), 8'd0);
        step(); chk("lw_s4", 8'(state), 8'd4); chk("lw_wb_regwrite", 8'(regwrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(memtoreg), 8'd1);
        step(); chk("lw_back", 8'(state), 8'd0); chk("lw_fetch_memtoreg", 8'(memtoreg), 8'd0);

        // R-type add: 0,1,6,7
        opcode = 6'b000000;
        chk("funct_pass", 8'(funct), 8'h20);
        step(); chk("r_s1", 8'(state), 8'd1);
        step(); chk("r_s6", 8'(state), 8'd6); chk("r_aluop", 8'(aluop), 8'd2);
        chk("r_srcb", 8'(alusrcb), 8'd0);
        step(); chk("r_s7", 8'(state), 8'd7); chk("r_regdst", 8'(regdst), 8'd1);
        chk("r_regwrite", 8'(regwrite), 8'd1);
        step(); chk("r_back", 8'(state), 8'd0);

        // beq taken / not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        step(); step();
        chk("beq_s8", 8'(state), 8'd8); chk("beq_pcen_taken", 8'(pcen), 8'd1);
        chk("beq_pcsrc", 8'(pcsrc), 8'd1); chk("beq_aluop", 8'(aluop), 8'd1);
        step(); chk("beq_back", 8'(state), 8'd0);
        zero = 1'b0;
        step(); step();
        chk("beq2_s8", 8'(state), 8'd8); chk("beq_pcen_nt", 8'(pcen), 8'd0);
        step();

        // FETCH stalled three cycles
        mem_ready = 1'b0;
        opcode    = 6'b111111;
        #1;
        chk("stall_irwrite", 8'(irwrite), 8'd0);
        chk("stall_pcen", 8'(pcen), 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_state", 8'(state), 8'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("unstall_irwrite", 8'(irwrite), 8'd1);

        // illegal opcode
        step(); chk("ill_s1", 8'(state), 8'd1); chk("ill_not_yet", 8'(illegal_op), 8'd0);
        step(); chk("ill_back", 8'(state), 8'd0); chk("ill_pulse", 8'(illegal_op), 8'd1);
        chk("ill_regwrite", 8'(regwrite), 8'd0); chk("ill_memwrite", 8'(memwrite), 8'd0);

        // ori: 0,1,10,11
        opcode = 6'b001101;
        step(); chk("ori_s1", 8'(state), 8'd1); chk("ill_cleared", 8'(illegal_op), 8'd0);
        step(); chk("ori_s10", 8'(state), 8'd10); chk("ori_aluop", 8'(aluop), 8'd3);
        chk("ori_zext", 8'(zext_imm), 8'd1);
        step(); chk("ori_s11", 8'(state), 8'd11); chk("ori_regwrite", 8'(regwrite), 8'd1);
        chk("ori_regdst", 8'(regdst), 8'd0);
        step(); chk("ori_back", 8'(state), 8'd0);

        // addi: 0,1,9,11
        opcode = 6'b001000;
        step(); step(); chk("addi_s9", 8'(state), 8'd9); chk("addi_zext", 8'(zext_imm), 8'd0);
        step(); chk("addi_s11", 8'(state), 8'd11);
        step();

        // jump: 0,1,12
        opcode = 6'b000010;
        step(); step(); chk("j_s12", 8'(state), 8'd12); chk("j_pcen", 8'(pcen), 8'd1);
        chk("j_pcsrc", 8'(pcsrc), 8'd2);
        step(); chk("j_back", 8'(state), 8'd0);

        // sw with mem_ready=1: 0,1,2,5,0
        opcode = 6'b101011;
        step(); step(); chk("sw_s2", 8'(state), 8'd2);
        step(); chk("sw_s5", 8'(state), 8'd5); chk("sw_memwrite", 8'(memwrite), 8'd1);
        chk("sw_iord", 8'(iord), 8'd1);
        step(); chk("sw_back", 8'(state), 8'd0);

        // sw stalled then reset mid-MEMWR
        step(); step(); step();
        chk("sw2_s5", 8'(state), 8'd5);
        mem_ready = 1'b0;
        step(); chk("sw2_hold", 8'(state), 8'd5); chk("sw2_hold_mw", 8'(memwrite), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 8'(state), 8'd0);
        chk("async_memwrite", 8'(memwrite), 8'd0);
        chk("async_regwrite", 8'(regwrite), 8'd0);
        step();
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_state", 8'(state), 8'd0);
        step(); chk("post_rst_decode", 8'(state), 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
